ram_rw_bridge: RTL and testbench
================================

Name: ram_rw_bridge

Overview:
- Parametrised successor to the simulation-top RAM glue.
- Converts the core's byte-addressed, sized ram_rw request into word-indexed RAMHelper accesses.
- Handles byte-lane alignment, write bit-masks, read extraction, programmable response latency and misalignment/range errors through a small handshake FSM.
- Sits between rvcpu and RAMHelper in the simulation top.

Parameters:
- DATA_W, 64: memory word width in bits; 32 or 64.
- ADDR_W, 64: address width.
- BASE_ADDR, 64'h8000_0000: address mapped to word index 0.
- LATENCY, 1: cycles from request accept to memory strobe; legal range 1..15.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- ram_rw_cen_i  input  1  request valid; held until ready
- ram_rw_wen_i  input  1  1 = write, 0 = read
- ram_rw_addr_i  input  ADDR_W  byte address
- ram_rw_wdata_i  input  DATA_W  write data, right-aligned
- ram_rw_size_i  input  3  [1:0] log2 bytes (0=B, 1=H, 2=W, 3=D); bit 2 ignored
- ram_rw_ready_o  output  1  one-cycle response pulse
- ram_rw_data_o  output  DATA_W  read data, right-aligned, zero-extended
- ram_rw_err_o  output  1  error flag, valid with ready
- mem_en_o  output  1  RAMHelper enable
- mem_idx_o  output  ADDR_W  word index (rIdx and wIdx)
- mem_rdata_i  input  DATA_W  RAMHelper combinational read data
- mem_wen_o  output  1  RAMHelper write enable
- mem_wdata_o  output  DATA_W  lane-shifted write data
- mem_wmask_o  output  DATA_W  bit-level write mask

Behaviour:
- Reset (async, rst_n=0): state IDLE; every output 0; latched request cleared. A write whose strobe has not yet been issued is dropped.
- Derived values:
  - OFFW = log2(DATA_W/8).
  - off = addr[OFFW-1:0].
  - nbytes = 1 << size[1:0].
  - idx = (addr - BASE_ADDR) >> OFFW, ADDR_W-bit unsigned subtraction.
- Error conditions, evaluated at accept:
  - (a) misaligned: off mod nbytes != 0;
  - (b) size exceeds word: nbytes > DATA_W/8;
  - (c) out of range: addr < BASE_ADDR.
- IDLE: if cen_i=1, latch wen, addr, wdata, size and the error flag; load cnt = LATENCY-1.
  - No error: go to WAIT.
  - Error: go to RESP directly.
  - If cen_i=0, stay in IDLE.
- WAIT: while cnt != 0, decrement; all mem outputs 0. When cnt == 0, for exactly one cycle:
  - mem_en_o=1 and mem_idx_o=idx;
  - mem_wen_o = latched wen;
  - mem_wdata_o = wdata << (8*off);
  - mem_wmask_o = ({nbytes*8{1'b1}}) << (8*off), all other bits 0;
  - on reads, capture (mem_rdata_i >> (8*off)) & low-nbytes mask at the clock edge;
  - go to RESP.
- RESP: ram_rw_ready_o=1 for exactly one cycle.
  - ram_rw_data_o = captured data on reads; 0 on writes and on errors.
  - ram_rw_err_o = latched error flag.
  - Next state IDLE.
- Outputs outside RESP: ready=0, err=0, data holds its last value.
- Latency: accept at cycle T, mem strobe at T+LATENCY, ready at T+LATENCY+1.
- Back-to-back requests: cen_i high in the IDLE cycle after RESP starts a new request. Minimum request spacing is LATENCY+2 cycles.
- Inputs are ignored outside IDLE. Changing them mid-request has no effect.
- Errored requests never assert mem_en_o or mem_wen_o. They respond at T+1.
- mem_en_o and mem_wen_o are registered (glitch-free) outputs.

Test Plan:
- Dword read, LATENCY=1: addr 0x8000_0010, mem word 2 = 0x1122334455667788 -> mem_idx_o=2 at T+1; ready at T+2 with data 0x1122334455667788, err=0.
- Byte write: addr 0x8000_0003, size 0, wdata 0xAB -> mem_wdata_o[31:24]=0xAB, mem_wmask_o=0x00000000FF000000, single mem_wen_o pulse.
- Half read at offset 6 from word 0xDEAD_BEEF_0000_1111 -> data 0x000000000000DEAD.
- Misaligned word access at addr 0x8000_0002, size 2 -> no mem strobe; ready at T+1 with err=1, data 0. Address 0x7FFF_FFF8 -> same response.
- LATENCY=4 with cen_i held high continuously -> ready pulses every 6 cycles; inputs toggled during WAIT are ignored.
- rst_n dropped during WAIT of a write before the strobe -> outputs 0 immediately, no mem_wen_o, FSM back in IDLE; the next request is serviced normally.

Source files
------------

// File: rtl/ram_rw_bridge.sv
// ram_rw_bridge: turns the core's byte-addressed, sized ram_rw request into a
// single word-indexed RAMHelper access after a programmable latency.
// Misaligned, oversized and below-base requests skip the memory and respond
// one cycle after accept with the error flag set.
module ram_rw_bridge #(
  parameter int          DATA_W    = 64,
  parameter int          ADDR_W    = 64,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int          LATENCY   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ram_rw_cen_i,
  input  logic              ram_rw_wen_i,
  input  logic [ADDR_W-1:0] ram_rw_addr_i,
  input  logic [DATA_W-1:0] ram_rw_wdata_i,
  input  logic [2:0]        ram_rw_size_i,
  output logic              ram_rw_ready_o,
  output logic [DATA_W-1:0] ram_rw_data_o,
  output logic              ram_rw_err_o,
  output logic              mem_en_o,
  output logic [ADDR_W-1:0] mem_idx_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              mem_wen_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [DATA_W-1:0] mem_wmask_o
);

  localparam int                NB       = DATA_W / 8;
  localparam int                OFFW     = $clog2(NB);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [3:0]        CNT_INIT = 4'(LATENCY - 1);
  localparam logic [3:0]        NB_W     = 4'(NB);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        size_q;

  logic              src_wen;
  logic [ADDR_W-1:0] src_addr;
  logic [DATA_W-1:0] src_wdata;
  logic [1:0]        src_size;
  logic [OFFW-1:0]   off;
  logic [OFFW+2:0]   shamt;
  logic [3:0]        nbytes;
  logic [DATA_W-1:0] lane_mask;
  logic [DATA_W-1:0] wdata_sh;
  logic [DATA_W-1:0] wmask_sh;
  logic [DATA_W-1:0] rdata_ext;
  logic [ADDR_W-1:0] idx;
  logic              req_err;
  logic              accept;
  logic              load_strobe;
  logic              size_unused;

  // size bit 2 carries no meaning for this bridge
  assign size_unused = ram_rw_size_i[2];

  assign accept = (state == IDLE) && ram_rw_cen_i;

  // The strobe is registered, so it is loaded one edge early: straight from
  // the live request when LATENCY is 1, otherwise from the latched request.
  assign load_strobe = (accept && !req_err && (LATENCY == 1)) ||
                       ((state == WAIT) && (cnt == 4'd1));

  // Derive lane position, masks and error from the live request in IDLE and
  // from the latched copy afterwards
  always_comb begin
    src_wen   = (state == IDLE) ? ram_rw_wen_i       : wen_q;
    src_addr  = (state == IDLE) ? ram_rw_addr_i      : addr_q;
    src_wdata = (state == IDLE) ? ram_rw_wdata_i     : wdata_q;
    src_size  = (state == IDLE) ? ram_rw_size_i[1:0] : size_q;
    off       = src_addr[OFFW-1:0];
    shamt     = {off, 3'b000};
    nbytes    = 4'd1 << src_size;
    idx       = (src_addr - BASE) >> OFFW;
    lane_mask = '0;
    for (int b = 0; b < NB; b++) begin
      if (4'(b) < nbytes) lane_mask[8*b +: 8] = 8'hFF;
    end
    wdata_sh  = src_wdata << shamt;
    wmask_sh  = lane_mask << shamt;
    rdata_ext = (mem_rdata_i >> shamt) & lane_mask;
    req_err   = ((4'(off) & (nbytes - 4'd1)) != 4'd0) ||
                (nbytes > NB_W) ||
                (src_addr < BASE);
  end

  // Request FSM; all outputs are registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      wen_q          <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      size_q         <= '0;
      ram_rw_ready_o <= 1'b0;
      ram_rw_data_o  <= '0;
      ram_rw_err_o   <= 1'b0;
      mem_en_o       <= 1'b0;
      mem_idx_o      <= '0;
      mem_wen_o      <= 1'b0;
      mem_wdata_o    <= '0;
      mem_wmask_o    <= '0;
    end else begin
      ram_rw_ready_o <= 1'b0;
      ram_rw_err_o   <= 1'b0;
      mem_en_o       <= 1'b0;
      mem_idx_o      <= '0;
      mem_wen_o      <= 1'b0;
      mem_wdata_o    <= '0;
      mem_wmask_o    <= '0;
      case (state)
        IDLE: begin
          if (ram_rw_cen_i) begin
            wen_q   <= ram_rw_wen_i;
            addr_q  <= ram_rw_addr_i;
            wdata_q <= ram_rw_wdata_i;
            size_q  <= ram_rw_size_i[1:0];
            cnt     <= CNT_INIT;
            if (req_err) begin
              state          <= RESP;
              ram_rw_ready_o <= 1'b1;
              ram_rw_err_o   <= 1'b1;
              ram_rw_data_o  <= '0;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state          <= RESP;
            ram_rw_ready_o <= 1'b1;
            ram_rw_data_o  <= wen_q ? '0 : rdata_ext;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (load_strobe) begin
        mem_en_o    <= 1'b1;
        mem_wen_o   <= src_wen;
        mem_idx_o   <= idx;
        mem_wdata_o <= wdata_sh;
        mem_wmask_o <= wmask_sh;
      end
    end
  end

endmodule

// File: tb/tb_ram_rw_bridge.sv
// Bench for ram_rw_bridge: two instances (LATENCY 1 and 4) share one request
// stream; each has its own RAM. A cycle-count reference model predicts every
// output, checked on each falling edge, plus hand-computed directed checks.
module tb_ram_rw_bridge;

  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam int          NW   = 32;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen   = 1'b0;
  logic        wen   = 1'b0;
  logic [63:0] addr  = '0;
  logic [63:0] wdata = '0;
  logic [2:0]  size  = '0;

  logic [1:0]  ready, err, en, mwen;
  logic [63:0] data_o  [0:1];
  logic [63:0] idx_o   [0:1];
  logic [63:0] wdata_o [0:1];
  logic [63:0] wmask_o [0:1];
  logic [63:0] rdata   [0:1];

  logic [63:0] ram     [0:1][0:NW-1];
  logic [63:0] ref_mem [0:1][0:NW-1];

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  ram_rw_bridge #(.DATA_W(64), .ADDR_W(64), .BASE_ADDR(BASE), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n),
    .ram_rw_cen_i(cen), .ram_rw_wen_i(wen), .ram_rw_addr_i(addr),
    .ram_rw_wdata_i(wdata), .ram_rw_size_i(size),
    .ram_rw_ready_o(ready[0]), .ram_rw_data_o(data_o[0]), .ram_rw_err_o(err[0]),
    .mem_en_o(en[0]), .mem_idx_o(idx_o[0]), .mem_rdata_i(rdata[0]),
    .mem_wen_o(mwen[0]), .mem_wdata_o(wdata_o[0]), .mem_wmask_o(wmask_o[0])
  );

  ram_rw_bridge #(.DATA_W(64), .ADDR_W(64), .BASE_ADDR(BASE), .LATENCY(4)) u_lat4 (
    .clk(clk), .rst_n(rst_n),
    .ram_rw_cen_i(cen), .ram_rw_wen_i(wen), .ram_rw_addr_i(addr),
    .ram_rw_wdata_i(wdata), .ram_rw_size_i(size),
    .ram_rw_ready_o(ready[1]), .ram_rw_data_o(data_o[1]), .ram_rw_err_o(err[1]),
    .mem_en_o(en[1]), .mem_idx_o(idx_o[1]), .mem_rdata_i(rdata[1]),
    .mem_wen_o(mwen[1]), .mem_wdata_o(wdata_o[1]), .mem_wmask_o(wmask_o[1])
  );

  // RAMHelper stand-ins: combinational read, masked write on the clock edge
  assign rdata[0] = ram[0][idx_o[0][4:0]];
  assign rdata[1] = ram[1][idx_o[1][4:0]];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (en[k] && mwen[k])
        ram[k][idx_o[k][4:0]] = (ram[k][idx_o[k][4:0]] & ~wmask_o[k]) | (wdata_o[k] & wmask_o[k]);
    end
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual %h expected %h", name, k, act, exp);
    end
  endtask

  // Reference model: per instance, tracks edges since accept. Strobe follows
  // the edge at t = lat-1, response at t = lat (t = 0 for errors), idle after.
  bit          m_busy [0:1];
  bit          m_err  [0:1];
  bit          m_wen  [0:1];
  bit          m_pw   [0:1];
  int          m_t    [0:1];
  int          m_pidx [0:1];
  logic [1:0]  m_size [0:1];
  logic [63:0] m_addr [0:1];
  logic [63:0] m_wdata[0:1];
  logic [63:0] m_rd   [0:1];
  logic [63:0] m_pdata[0:1];
  logic [63:0] m_pmask[0:1];
  bit          e_en   [0:1];
  bit          e_wen  [0:1];
  bit          e_ready[0:1];
  bit          e_err  [0:1];
  logic [63:0] e_idx  [0:1];
  logic [63:0] e_wdata[0:1];
  logic [63:0] e_wmask[0:1];
  logic [63:0] e_data [0:1];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_busy[k] = 1'b0; m_pw[k] = 1'b0; m_t[k] = 0; m_rd[k] = '0;
        e_en[k] = 1'b0; e_wen[k] = 1'b0; e_ready[k] = 1'b0; e_err[k] = 1'b0;
        e_idx[k] = '0; e_wdata[k] = '0; e_wmask[k] = '0; e_data[k] = '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        int lat, nb, off, resp_t;
        logic [63:0] lm, widx;
        lat = lat_of(k);
        if (m_pw[k]) begin
          ref_mem[k][m_pidx[k]] = (ref_mem[k][m_pidx[k]] & ~m_pmask[k]) | (m_pdata[k] & m_pmask[k]);
          m_pw[k] = 1'b0;
        end
        e_en[k] = 1'b0; e_wen[k] = 1'b0; e_ready[k] = 1'b0; e_err[k] = 1'b0;
        e_idx[k] = '0; e_wdata[k] = '0; e_wmask[k] = '0;
        if (m_busy[k]) begin
          m_t[k]++;
          resp_t = m_err[k] ? 0 : lat;
          if (m_t[k] > resp_t) m_busy[k] = 1'b0;
        end else if (cen) begin
          m_busy[k] = 1'b1; m_t[k] = 0;
          m_wen[k] = wen; m_addr[k] = addr; m_wdata[k] = wdata; m_size[k] = size[1:0];
          nb  = 1 << size[1:0];
          off = int'(addr[2:0]);
          m_err[k] = ((off % nb) != 0) || (nb > 8) || (addr < BASE);
        end
        if (m_busy[k]) begin
          nb   = 1 << m_size[k];
          off  = int'(m_addr[k][2:0]);
          lm   = (nb == 8) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
          widx = (m_addr[k] - BASE) >> 3;
          if (!m_err[k] && m_t[k] == lat - 1) begin
            e_en[k] = 1'b1; e_wen[k] = m_wen[k]; e_idx[k] = widx;
            e_wdata[k] = m_wdata[k] << (8 * off);
            e_wmask[k] = lm << (8 * off);
            if (m_wen[k]) begin
              m_pw[k] = 1'b1; m_pidx[k] = int'(widx[4:0]);
              m_pdata[k] = e_wdata[k]; m_pmask[k] = e_wmask[k];
            end else begin
              m_rd[k] = (ref_mem[k][widx[4:0]] >> (8 * off)) & lm;
            end
          end
          if (m_t[k] == (m_err[k] ? 0 : lat)) begin
            e_ready[k] = 1'b1; e_err[k] = m_err[k];
            e_data[k]  = (m_err[k] || m_wen[k]) ? 64'd0 : m_rd[k];
          end
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (cmp_on) begin
      for (int k = 0; k < 2; k++) begin
        chk("ready", k, 64'(ready[k]), 64'(e_ready[k]));
        chk("err",   k, 64'(err[k]),   64'(e_err[k]));
        chk("data",  k, data_o[k],     e_data[k]);
        chk("en",    k, 64'(en[k]),    64'(e_en[k]));
        chk("wen",   k, 64'(mwen[k]),  64'(e_wen[k]));
        chk("idx",   k, idx_o[k],      e_idx[k]);
        chk("wdata", k, wdata_o[k],    e_wdata[k]);
        chk("wmask", k, wmask_o[k],    e_wmask[k]);
      end
    end
  end

  task automatic issue(input bit w, input logic [63:0] a, input logic [63:0] d, input logic [2:0] s);
    @(posedge clk); #1;
    wen = w; addr = a; wdata = d; size = s; cen = 1'b1;
    @(posedge clk); #1;
    cen = 1'b0;
  endtask

  task automatic rand_valid();
    int s, nb;
    s  = int'($urandom % 4);
    nb = 1 << s;
    wen   = 1'($urandom);
    wdata = {$urandom, $urandom};
    size  = 3'(s);
    addr  = BASE + 64'(($urandom % NW) * 8) + 64'(int'($urandom % 8) & ~(nb - 1));
  endtask

  task automatic rand_any();
    wen   = 1'($urandom);
    wdata = {$urandom, $urandom};
    size  = 3'($urandom);
    addr  = BASE - 64'd16 + 64'($urandom % (NW * 8 + 16));
  endtask

  initial begin
    int last0, last1;
    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < NW; w++) ram[k][w] = {$urandom, $urandom};
      ram[k][2] = 64'h1122_3344_5566_7788;
      ram[k][3] = 64'hDEAD_BEEF_0000_1111;
      ram[k][5] = 64'h0123_4567_89AB_CDEF;
      for (int w = 0; w < NW; w++) ref_mem[k][w] = ram[k][w];
    end
    repeat (3) @(posedge clk);
    cmp_on = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_ready", k, 64'(ready[k]), 64'd0);
      chk("rst_en",    k, 64'(en[k]),    64'd0);
      chk("rst_data",  k, data_o[k],     64'd0);
    end
    @(negedge clk) rst_n = 1'b1;

    // dword read, LATENCY 1
    issue(1'b0, BASE + 64'h10, 64'd0, 3'd3);
    chk("dw_en",  0, 64'(en[0]), 64'd1);
    chk("dw_idx", 0, idx_o[0],   64'd2);
    @(posedge clk); #1;
    chk("dw_ready", 0, 64'(ready[0]), 64'd1);
    chk("dw_data",  0, data_o[0],     64'h1122_3344_5566_7788);
    chk("dw_err",   0, 64'(err[0]),   64'd0);
    repeat (6) @(posedge clk);

    // misaligned word and below-base dword: immediate error response
    issue(1'b0, BASE + 64'h2, 64'd0, 3'd2);
    for (int k = 0; k < 2; k++) begin
      chk("mis_ready", k, 64'(ready[k]), 64'd1);
      chk("mis_err",   k, 64'(err[k]),   64'd1);
      chk("mis_data",  k, data_o[k],     64'd0);
      chk("mis_en",    k, 64'(en[k]),    64'd0);
    end
    repeat (3) @(posedge clk);
    issue(1'b0, 64'h7FFF_FFF8, 64'd0, 3'd3);
    for (int k = 0; k < 2; k++) begin
      chk("low_ready", k, 64'(ready[k]), 64'd1);
      chk("low_err",   k, 64'(err[k]),   64'd1);
      chk("low_en",    k, 64'(en[k]),    64'd0);
    end
    repeat (3) @(posedge clk);

    // byte write at offset 3
    issue(1'b1, BASE + 64'h3, 64'hAB, 3'd0);
    chk("bw_wen",  0, 64'(mwen[0]),          64'd1);
    chk("bw_lane", 0, 64'(wdata_o[0][31:24]), 64'hAB);
    chk("bw_mask", 0, wmask_o[0],             64'h0000_0000_FF00_0000);
    @(posedge clk); #1;
    chk("bw_wen_off", 0, 64'(mwen[0]), 64'd0);
    repeat (6) @(posedge clk);

    // half read at offset 6
    issue(1'b0, BASE + 64'h1E, 64'd0, 3'd1);
    @(posedge clk); #1;
    chk("hr_data", 0, data_o[0], 64'h0000_0000_0000_DEAD);
    repeat (3) @(posedge clk); #1;
    chk("hr_ready4", 1, 64'(ready[1]), 64'd1);
    chk("hr_data4",  1, data_o[1],     64'h0000_0000_0000_DEAD);
    repeat (3) @(posedge clk);

    // reset during the WAIT of a LATENCY-4 write, before its strobe
    issue(1'b1, BASE + 64'h28, 64'h5555_5555_5555_5555, 3'd3);
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("ar_ready", k, 64'(ready[k]), 64'd0);
      chk("ar_en",    k, 64'(en[k]),    64'd0);
      chk("ar_wen",   k, 64'(mwen[k]),  64'd0);
      chk("ar_data",  k, data_o[k],     64'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    issue(1'b0, BASE + 64'h10, 64'd0, 3'd3);
    repeat (3) @(posedge clk); #1;
    chk("rr_en",  1, 64'(en[1]), 64'd1);
    chk("rr_idx", 1, idx_o[1],   64'd2);
    @(posedge clk); #1;
    chk("rr_ready", 1, 64'(ready[1]), 64'd1);
    chk("rr_data",  1, data_o[1],     64'h1122_3344_5566_7788);
    chk("drop_mem", 1, ram[1][5], 64'h0123_4567_89AB_CDEF);
    chk("done_mem", 0, ram[0][5], 64'h5555_5555_5555_5555);
    repeat (3) @(posedge clk);

    // cen held high with valid requests changing every cycle
    @(posedge clk); #1;
    cen = 1'b1;
    rand_valid();
    last0 = -1;
    last1 = -1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (ready[0]) begin
        if (last0 >= 0) chk("cadence", 0, 64'(c - last0), 64'd3);
        last0 = c;
      end
      if (ready[1]) begin
        if (last1 >= 0) chk("cadence", 1, 64'(c - last1), 64'd6);
        last1 = c;
      end
      rand_valid();
    end
    chk("cadence_seen", 1, 64'(last1 >= 0), 64'd1);

    // random traffic including misaligned and below-base requests
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      cen = ($urandom % 4) != 0;
      rand_any();
    end
    cen = 1'b0;
    repeat (10) @(posedge clk); #1;
    for (int k = 0; k < 2; k++)
      for (int w = 0; w < NW; w++)
        chk("mem", k, ram[k][w], ref_mem[k][w]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
